instruction_fetch_unit: RTL and testbench

Front-end stage that owns PC/nPC, reads the next instruction word from RAM with the MFC handshake, and presents it as `IR_Out` to the control unit. It sits directly upstream of the control unit. The control unit consumes each instruction through a valid/ready pair and returns the branch decision. SPARC delayed-branch semantics: a taken branch redirects nPC, not PC.

---
 rtl/instruction_fetch_unit_pkg.sv | 20 ++
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit_timeout.sv | 39 +++
 rtl/instruction_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared SPARC front-end definitions.
// Fetch FSM states and the fetch bus constants.
package sparc_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [5:0]  OP_LD_WORD  = 6'b000000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [1:0]  ALIGN_MASK  = 2'b11;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory bus with the MFC completion handshake.
// master = fetch unit, slave = memory.
interface instruction_fetch_unit_if;

    logic        RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] RAM_addr;
    logic [31:0] RAM_data;
    logic        MFC;

    modport master (
        output RAM_enable,
        output RAM_OpCode,
        output RAM_addr,
        input  RAM_data,
        input  MFC
    );

    modport slave (
        input  RAM_enable,
        input  RAM_OpCode,
        input  RAM_addr,
        output RAM_data,
        output MFC
    );

endinterface

// File: rtl/instruction_fetch_unit_timeout.sv
// Wait-cycle counter for an outstanding memory read.
// tc_o flags the last cycle allowed before the request is declared lost.
module fetch_timeout_counter #(
    parameter int unsigned MFC_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic       tc_o,
    output logic [7:0] count_o
);

    localparam logic [7:0] TC_VAL = 8'(MFC_TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o    = (count_q == TC_VAL);
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// SPARC fetch stage: owns PC/nPC, reads one word per instruction and
// hands it to the control unit; taken branches redirect nPC (delay slot).
module instruction_fetch_unit
    import sparc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MFC_TIMEOUT = 16
) (
    input  logic                      Clk,
    input  logic                      RESET,
    instruction_fetch_unit_if.master  ram,
    output logic [31:0]               IR_Out,
    output logic                      ir_valid,
    input  logic                      ir_ready,
    input  logic                      branch_taken,
    input  logic [31:0]               branch_target,
    output logic [31:0]               PC_out,
    output logic [31:0]               nPC_out,
    output logic                      fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  npc_q, npc_d;
    logic [31:0]  ir_q, ir_d;
    logic         valid_q, valid_d;
    logic         en_q, en_d;
    logic [5:0]   op_q, op_d;
    logic [31:0]  addr_q, addr_d;
    logic         fault_q, fault_d;

    logic         tmr_clr;
    logic         tmr_inc;
    logic         tmr_tc;
    logic [7:0]   tmr_count;

    fetch_timeout_counter #(
        .MFC_TIMEOUT (MFC_TIMEOUT)
    ) u_timeout (
        .clk_i   (Clk),
        .rst_i   (RESET),
        .clr_i   (tmr_clr),
        .inc_i   (tmr_inc),
        .tc_o    (tmr_tc),
        .count_o (tmr_count)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        en_d    = en_q;
        op_d    = op_q;
        addr_d  = addr_q;
        fault_d = fault_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;

        unique case (state_q)
            FS_IDLE: begin
                if (is_misaligned(pc_q)) begin
                    fault_d = 1'b1;
                    state_d = FS_FAULT;
                end else begin
                    addr_d  = pc_q;
                    en_d    = 1'b1;
                    op_d    = OP_LD_WORD;
                    tmr_clr = 1'b1;
                    state_d = FS_WAIT;
                end
            end
            // MFC takes priority over the timeout on the same edge
            FS_WAIT: begin
                if (ram.MFC) begin
                    ir_d    = ram.RAM_data;
                    valid_d = 1'b1;
                    en_d    = 1'b0;
                    op_d    = '0;
                    state_d = FS_HOLD;
                end else if (tmr_tc) begin
                    en_d    = 1'b0;
                    op_d    = '0;
                    fault_d = 1'b1;
                    state_d = FS_FAULT;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            FS_HOLD: begin
                if (valid_q && ir_ready) begin
                    pc_d    = npc_q;
                    npc_d   = branch_taken ? branch_target
                                           : npc_q + INSTR_BYTES;
                    valid_d = 1'b0;
                    state_d = FS_IDLE;
                end
            end
            FS_FAULT: begin
                fault_d = 1'b1;
                en_d    = 1'b0;
                op_d    = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC + INSTR_BYTES;
            ir_q    <= '0;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            en_q    <= en_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            fault_q <= fault_d;
        end
    end

    assign ram.RAM_enable = en_q;
    assign ram.RAM_OpCode = op_q;
    assign ram.RAM_addr   = addr_q;

    assign IR_Out      = ir_q;
    assign ir_valid    = valid_q;
    assign PC_out      = pc_q;
    assign nPC_out     = npc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Memory and control unit are driven by hand from one initial block.
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        RESET;
    logic [31:0] IR_Out;
    logic        ir_valid;
    logic        ir_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] PC_out;
    logic [31:0] nPC_out;
    logic        fetch_fault;

    int total;
    int bad;

    instruction_fetch_unit_if ram ();

    instruction_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .MFC_TIMEOUT (16)
    ) dut (
        .Clk           (Clk),
        .RESET         (RESET),
        .ram           (ram),
        .IR_Out        (IR_Out),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .PC_out        (PC_out),
        .nPC_out       (nPC_out),
        .fetch_fault   (fetch_fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        RESET         = 1'b1;
        ir_ready      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        ram.MFC       = 1'b1;
        ram.RAM_data  = 32'h8200_4003;

        // reset values, MFC already high
        tick();
        tick();
        chk("rst_en",    32'(ram.RAM_enable), 32'd0);
        chk("rst_op",    32'(ram.RAM_OpCode), 32'd0);
        chk("rst_addr",  ram.RAM_addr, 32'h0);
        chk("rst_ir",    IR_Out, 32'h0);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_pc",    PC_out, 32'h0);
        chk("rst_npc",   nPC_out, 32'h4);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        RESET = 1'b0;

        // streaming fetch, zero-wait memory
        tick();
        chk("e0_en",    32'(ram.RAM_enable), 32'd1);
        chk("e0_addr",  ram.RAM_addr, 32'h0);
        chk("e0_valid", 32'(ir_valid), 32'd0);
        tick();
        chk("e1_valid", 32'(ir_valid), 32'd1);
        chk("e1_ir",    IR_Out, 32'h8200_4003);
        chk("e1_en",    32'(ram.RAM_enable), 32'd0);
        tick();
        chk("e2_valid", 32'(ir_valid), 32'd0);
        chk("e2_pc",    PC_out, 32'h4);
        chk("e2_npc",   nPC_out, 32'h8);
        tick();
        chk("e3_en",    32'(ram.RAM_enable), 32'd1);
        chk("e3_addr",  ram.RAM_addr, 32'h4);
        tick();
        tick();
        tick();
        chk("e6_addr",  ram.RAM_addr, 32'h8);

        // branch at PC=8 to 0x100, delay slot at 12
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        tick();
        tick();
        branch_taken  = 1'b0;
        branch_target = 32'hDEAD_0000;
        chk("br_pc",   PC_out, 32'hC);
        chk("br_npc",  nPC_out, 32'h100);
        tick();
        chk("ds_addr", ram.RAM_addr, 32'hC);
        tick();
        tick();
        chk("ds_pc",   PC_out, 32'h100);
        chk("ds_npc",  nPC_out, 32'h104);
        tick();
        chk("tg_addr", ram.RAM_addr, 32'h100);
        tick();
        tick();
        tick();
        chk("tg4_addr", ram.RAM_addr, 32'h104);

        // MFC delayed: request held stable
        ir_ready = 1'b0;
        ram.MFC  = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dly_en",   32'(ram.RAM_enable), 32'd1);
            chk("dly_addr", ram.RAM_addr, 32'h0);
            chk("dly_val",  32'(ir_valid), 32'd0);
        end
        ram.MFC      = 1'b1;
        ram.RAM_data = 32'h1234_5678;
        tick();
        chk("dly_valid", 32'(ir_valid), 32'd1);
        chk("dly_ir",    IR_Out, 32'h1234_5678);
        ram.RAM_data = 32'hCAFE_F00D;
        tick();
        tick();
        chk("hold_ir",    IR_Out, 32'h1234_5678);
        chk("hold_valid", 32'(ir_valid), 32'd1);
        chk("hold_pc",    PC_out, 32'h0);
        chk("hold_en",    32'(ram.RAM_enable), 32'd0);

        // MFC never returns: fault after 16 WAIT cycles
        ram.MFC = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to15_en",    32'(ram.RAM_enable), 32'd1);
        chk("to15_fault", 32'(fetch_fault), 32'd0);
        tick();
        chk("to16_fault", 32'(fetch_fault), 32'd1);
        chk("to16_en",    32'(ram.RAM_enable), 32'd0);
        chk("to16_valid", 32'(ir_valid), 32'd0);
        ram.MFC = 1'b1;
        tick();
        tick();
        chk("flt_sticky", 32'(fetch_fault), 32'd1);
        chk("flt_noreq",  32'(ram.RAM_enable), 32'd0);
        RESET = 1'b1;
        tick();
        chk("flt_clr",    32'(fetch_fault), 32'd0);
        chk("flt_npc",    nPC_out, 32'h4);

        // MFC on the timeout boundary wins
        ram.MFC = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 15; i++) tick();
        ram.MFC      = 1'b1;
        ram.RAM_data = 32'hA5A5_0001;
        tick();
        chk("edge_valid", 32'(ir_valid), 32'd1);
        chk("edge_fault", 32'(fetch_fault), 32'd0);
        chk("edge_ir",    IR_Out, 32'hA5A5_0001);

        // misaligned branch target faults without a request
        ir_ready = 1'b1;
        do_reset();
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h102;
        tick();
        tick();
        branch_taken  = 1'b0;
        chk("mis_npc", nPC_out, 32'h102);
        tick();
        tick();
        tick();
        chk("mis_pc",  PC_out, 32'h102);
        tick();
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_en",    32'(ram.RAM_enable), 32'd0);
        tick();
        chk("mis_en2",   32'(ram.RAM_enable), 32'd0);

        // nPC wrap-around
        do_reset();
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        tick();
        branch_taken  = 1'b0;
        tick();
        tick();
        tick();
        chk("wrap_pc",   PC_out, 32'hFFFF_FFFC);
        chk("wrap_npc",  nPC_out, 32'h0);
        tick();
        chk("wrap_addr", ram.RAM_addr, 32'hFFFF_FFFC);
        chk("wrap_en",   32'(ram.RAM_enable), 32'd1);

        // RESET mid-WAIT, late MFC ignored
        ram.MFC  = 1'b0;
        ir_ready = 1'b0;
        do_reset();
        tick();
        tick();
        RESET = 1'b1;
        tick();
        chk("abort_en", 32'(ram.RAM_enable), 32'd0);
        RESET        = 1'b0;
        ram.MFC      = 1'b1;
        ram.RAM_data = 32'hDEAD_BEEF;
        tick();
        ram.MFC = 1'b0;
        chk("late_valid", 32'(ir_valid), 32'd0);
        chk("late_ir",    IR_Out, 32'h0);
        chk("restart_en", 32'(ram.RAM_enable), 32'd1);
        chk("restart_a",  ram.RAM_addr, 32'h0);
        tick();
        chk("late_valid2", 32'(ir_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
